// File: rtl/scanlines_pkg.sv
// scanlines_pro shared types and helpers
// mode/level encodings and parameter legality check
package scanlines_pkg;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_ALT = 2'd1,
    SL_PER = 2'd2,
    SL_COL = 2'd3
  } sl_mode_e;

  typedef enum logic [1:0] {
    LV_NONE = 2'd0,
    LV_3Q   = 2'd1,
    LV_HALF = 2'd2,
    LV_1Q   = 2'd3
  } sl_level_e;

  function automatic bit sl_params_ok(
    input int dw,
    input int ch,
    input int lat,
    input int pw
  );
    return (dw >= 4) && (dw <= 12) &&
           (ch >= 1) && (ch <= 4) &&
           (lat >= 2) && (lat <= 8) &&
           (pw >= 1) && (pw <= 16);
  endfunction

endpackage

// File: rtl/scanlines_pro_dim.sv
// scanline_dim: one-channel combinational attenuator
// truncating shifts, result never exceeds the input
module scanline_dim
  import scanlines_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [1:0]    level,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] y
);

  // select the dimmed value for this channel
  always_comb begin
    y = c;
    unique case (sl_level_e'(level))
      LV_NONE: y = c;
      LV_3Q:   y = (c >> 1) + (c >> 2);
      LV_HALF: y = c >> 1;
      LV_1Q:   y = c >> 2;
    endcase
  end

endmodule

// File: rtl/scanlines_pro.sv
// scanlines_pro: line/column dimming on a pixel stream
// controls latch at vs fall; all outputs delayed LAT clocks
module scanlines_pro
  import scanlines_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CH  = 3,
  parameter int LAT = 3,
  parameter int PW  = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     mode,
  input  logic [1:0]     level,
  input  logic [PW-1:0]  period,
  input  logic [CH*DW-1:0] din,
  input  logic           hs_in,
  input  logic           vs_in,
  input  logic           de_in,
  output logic [CH*DW-1:0] dout,
  output logic           hs_out,
  output logic           vs_out,
  output logic           de_out
);

  if (!sl_params_ok(DW, CH, LAT, PW)) begin : g_bad_params
    $error("scanlines_pro: parameter out of range");
  end

  logic           hs_q;
  logic           vs_q;
  logic           de_q;
  logic           hs_fall;
  logic           vs_fall;
  logic           de_rise;
  sl_mode_e       mode_q;
  logic [1:0]     level_q;
  logic [PW-1:0]  period_q;
  logic [PW-1:0]  eff_p;
  logic [PW-1:0]  lc;
  logic [PW-1:0]  cc;
  logic [PW-1:0]  cc_cur;
  logic           dim;
  logic [CH*DW-1:0] att;
  logic [CH*DW-1:0] pix_sel;
  logic [CH*DW-1:0] pix_d [LAT];
  logic [2:0]     sync_d [LAT];

  assign hs_fall = hs_q & ~hs_in;
  assign vs_fall = vs_q & ~vs_in;
  assign de_rise = de_in & ~de_q;
  assign eff_p   = (period_q == '0) ? PW'(1) : period_q;
  // first pixel of a DE run always sees a cleared column count
  assign cc_cur  = de_rise ? '0 : cc;

  // previous-cycle copies for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      hs_q <= hs_in;
      vs_q <= vs_in;
      de_q <= de_in;
    end
  end

  // frame-synchronous control shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= SL_OFF;
      level_q  <= 2'd0;
      period_q <= '0;
    end else if (vs_fall) begin
      mode_q   <= sl_mode_e'(mode);
      level_q  <= level;
      period_q <= period;
    end
  end

  // line counter; vs fall takes priority over hs fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lc <= '0;
    end else if (vs_fall) begin
      lc <= '0;
    end else if (hs_fall) begin
      case (mode_q)
        SL_ALT:  lc[0] <= ~lc[0];
        SL_PER:  lc <= (lc >= eff_p) ? '0 : lc + PW'(1);
        default: lc <= lc;
      endcase
    end
  end

  // column counter advancing on active pixels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc <= '0;
    end else if (de_in) begin
      cc <= (cc_cur >= eff_p) ? '0 : cc_cur + PW'(1);
    end
  end

  // dim decision from pre-update counters
  always_comb begin
    dim = 1'b0;
    case (mode_q)
      SL_ALT:  dim = lc[0];
      SL_PER:  dim = (lc == eff_p);
      SL_COL:  dim = de_in && (cc_cur == eff_p);
      default: dim = 1'b0;
    endcase
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    scanline_dim #(
      .DW(DW)
    ) u_dim (
      .level (level_q),
      .c     (din[(CH-1-g)*DW +: DW]),
      .y     (att[(CH-1-g)*DW +: DW])
    );
  end

  assign pix_sel = dim ? att : din;

  // matched delay line for pixel and sync/DE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        pix_d[i]  <= '0;
        sync_d[i] <= '0;
      end
    end else begin
      pix_d[0]  <= pix_sel;
      sync_d[0] <= {hs_in, vs_in, de_in};
      for (int i = 1; i < LAT; i++) begin
        pix_d[i]  <= pix_d[i-1];
        sync_d[i] <= sync_d[i-1];
      end
    end
  end

  assign dout   = pix_d[LAT-1];
  assign hs_out = sync_d[LAT-1][2];
  assign vs_out = sync_d[LAT-1][1];
  assign de_out = sync_d[LAT-1][0];

endmodule
